// File: rtl/control_unit_seq_pkg.sv
// Shared encodings and decode helpers for the registered ID-stage control unit.
// Mode, opcode and execute-command codes are common to every decoder in the ID stage.
package control_unit_seq_pkg;

   localparam logic [1:0] ModeArith  = 2'b00;
   localparam logic [1:0] ModeMem    = 2'b01;
   localparam logic [1:0] ModeBranch = 2'b10;
   localparam logic [1:0] ModeBlock  = 2'b11;

   localparam logic [3:0] OpMov = 4'd0;
   localparam logic [3:0] OpMvn = 4'd1;
   localparam logic [3:0] OpAdd = 4'd2;
   localparam logic [3:0] OpAdc = 4'd3;
   localparam logic [3:0] OpSub = 4'd4;
   localparam logic [3:0] OpSbc = 4'd5;
   localparam logic [3:0] OpAnd = 4'd6;
   localparam logic [3:0] OpOrr = 4'd7;
   localparam logic [3:0] OpEor = 4'd8;
   localparam logic [3:0] OpCmp = 4'd9;
   localparam logic [3:0] OpTst = 4'd10;
   localparam logic [3:0] OpMul = 4'd11;

   // Each arithmetic execute command sits exactly one above its opcode.
   localparam logic [3:0] ExecNop = 4'd0;
   localparam logic [3:0] ExecMov = 4'd1;
   localparam logic [3:0] ExecMvn = 4'd2;
   localparam logic [3:0] ExecAdd = 4'd3;
   localparam logic [3:0] ExecAdc = 4'd4;
   localparam logic [3:0] ExecSub = 4'd5;
   localparam logic [3:0] ExecSbc = 4'd6;
   localparam logic [3:0] ExecAnd = 4'd7;
   localparam logic [3:0] ExecOrr = 4'd8;
   localparam logic [3:0] ExecEor = 4'd9;
   localparam logic [3:0] ExecCmp = 4'd10;
   localparam logic [3:0] ExecTst = 4'd11;
   localparam logic [3:0] ExecMul = 4'd12;
   localparam logic [3:0] ExecMem = 4'd13;

   typedef enum logic [1:0] {StIdle, StBlock, StMulWait} state_e;

   typedef struct packed {
      logic       valid;
      logic [3:0] exec;
      logic       mem_read;
      logic       mem_write;
      logic       wb_en;
      logic       branch;
      logic       status_update_en;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t Bubble = '0;

   function automatic ctrl_t decode_arith(input logic [3:0] op, input logic s);
      ctrl_t c;
      c = Bubble;
      c.valid = 1'b1;
      case (op)
         OpMov, OpMvn, OpAdd, OpAdc, OpSub, OpSbc, OpAnd, OpOrr, OpEor, OpMul: begin
            c.exec             = op + 4'd1;
            c.wb_en            = 1'b1;
            c.status_update_en = s;
         end
         OpCmp, OpTst: begin
            c.exec             = op + 4'd1;
            c.status_update_en = s;
         end
         default: c.illegal = 1'b1;
      endcase
      return c;
   endfunction

   function automatic ctrl_t mem_word(input logic load);
      ctrl_t c;
      c = Bubble;
      c.valid     = 1'b1;
      c.exec      = ExecMem;
      c.mem_read  = load;
      c.wb_en     = load;
      c.mem_write = ~load;
      return c;
   endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// Combinational priority encoder: index of the lowest set bit and a flag for exactly one bit set.
// W must be at least 2 so the index has a non-zero width.
module lowest_set_bit #(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0]         vec_i,
   output logic [$clog2(W)-1:0] idx_o,
   output logic                 one_left_o
);

   localparam int unsigned IdxW = $clog2(W);

   // Scan downward so the lowest set bit is the last to write.
   always_comb begin
      idx_o = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec_i[i]) idx_o = IdxW'(i);
      end
   end

   assign one_left_o = (vec_i != '0) && ((vec_i & (vec_i - W'(1))) == '0);

endmodule

// File: rtl/control_unit_seq.sv
// ID-stage control unit: registers decoded control words into the ID/EX boundary and
// sequences MUL occupancy and LDM/STM beats, with flush and stall handling.
module control_unit_seq
   import control_unit_seq_pkg::*;
#(
   parameter int unsigned MODE_LEN     = 2,
   parameter int unsigned OPCODE_LEN   = 4,
   parameter int unsigned EXEC_CMD_LEN = 4,
   parameter int unsigned REG_LIST_W   = 16,
   parameter int unsigned MUL_CYCLES   = 4,
   localparam int unsigned IDX_W       = $clog2(REG_LIST_W)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [MODE_LEN-1:0]     mode,
   input  logic [OPCODE_LEN-1:0]   opcode,
   input  logic                    s,
   input  logic [REG_LIST_W-1:0]   reg_list,
   input  logic                    stall_in,
   input  logic                    flush,
   output logic                    out_valid,
   output logic [EXEC_CMD_LEN-1:0] exec_command,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic                    wb_en,
   output logic                    branch,
   output logic                    status_update_en,
   output logic                    illegal,
   output logic [IDX_W-1:0]        xfer_reg_idx,
   output logic                    xfer_first,
   output logic                    xfer_last,
   output logic                    busy
);

   localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   state_e                state_d, state_q;
   ctrl_t                 ctrl_d, ctrl_q;
   logic [REG_LIST_W-1:0] pending_d, pending_q;
   logic                  dir_d, dir_q;
   logic [CntW-1:0]       cnt_d, cnt_q;
   logic [IDX_W-1:0]      idx_d, idx_q;
   logic                  first_d, first_q;
   logic                  last_d, last_q;

   logic [REG_LIST_W-1:0] scan;
   logic [IDX_W-1:0]      scan_idx;
   logic                  scan_one;

   assign in_ready = (state_q == StIdle) && !stall_in;

   // The first beat comes straight from reg_list on the accept edge; later beats from pending.
   assign scan = (state_q == StIdle) ? reg_list : pending_q;

   lowest_set_bit #(.W(REG_LIST_W)) u_lsb (
      .vec_i      (scan),
      .idx_o      (scan_idx),
      .one_left_o (scan_one)
   );

   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      pending_d = pending_q;
      dir_d     = dir_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      first_d   = first_q;
      last_d    = last_q;
      if (flush) begin
         state_d   = StIdle;
         ctrl_d    = Bubble;
         pending_d = '0;
         cnt_d     = '0;
         idx_d     = '0;
         first_d   = 1'b0;
         last_d    = 1'b0;
      end else if (!stall_in) begin
         ctrl_d  = Bubble;
         idx_d   = '0;
         first_d = 1'b0;
         last_d  = 1'b0;
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  unique case (mode)
                     ModeArith: begin
                        ctrl_d = decode_arith(opcode, s);
                        if (opcode == OpMul && MUL_CYCLES > 1) begin
                           state_d = StMulWait;
                           cnt_d   = CntW'(MUL_CYCLES - 1);
                        end
                     end
                     ModeMem: ctrl_d = mem_word(s);
                     ModeBranch: begin
                        ctrl_d.valid  = 1'b1;
                        ctrl_d.branch = 1'b1;
                     end
                     default: begin
                        dir_d     = s;
                        pending_d = reg_list & (reg_list - REG_LIST_W'(1));
                        if (reg_list == '0) begin
                           ctrl_d.valid   = 1'b1;
                           ctrl_d.illegal = 1'b1;
                        end else begin
                           ctrl_d  = mem_word(s);
                           idx_d   = scan_idx;
                           first_d = 1'b1;
                           last_d  = scan_one;
                           if (!scan_one) state_d = StBlock;
                        end
                     end
                  endcase
               end
            end
            StBlock: begin
               ctrl_d    = mem_word(dir_q);
               idx_d     = scan_idx;
               last_d    = scan_one;
               pending_d = pending_q & (pending_q - REG_LIST_W'(1));
               if (scan_one) state_d = StIdle;
            end
            StMulWait: begin
               cnt_d = cnt_q - CntW'(1);
               if (cnt_q <= CntW'(1)) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ctrl_q    <= Bubble;
         pending_q <= '0;
         dir_q     <= 1'b0;
         cnt_q     <= '0;
         idx_q     <= '0;
         first_q   <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         pending_q <= pending_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         first_q   <= first_d;
         last_q    <= last_d;
      end
   end

   assign out_valid        = ctrl_q.valid;
   assign exec_command     = EXEC_CMD_LEN'(ctrl_q.exec);
   assign mem_read         = ctrl_q.mem_read;
   assign mem_write        = ctrl_q.mem_write;
   assign wb_en            = ctrl_q.wb_en;
   assign branch           = ctrl_q.branch;
   assign status_update_en = ctrl_q.status_update_en;
   assign illegal          = ctrl_q.illegal;
   assign xfer_reg_idx     = idx_q;
   assign xfer_first       = first_q;
   assign xfer_last        = last_q;
   assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_control_unit_seq.sv
// Bench for control_unit_seq: directed scenarios plus random traffic against a
// transaction-level model (beat queue, MUL bubble count).
module tb_control_unit_seq;
   import control_unit_seq_pkg::*;

   localparam int unsigned MulCycles = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  mode = '0;
   logic [3:0]  opcode = '0;
   logic        s = 1'b0;
   logic [15:0] reg_list = '0;
   logic        stall_in = 1'b0;
   logic        flush = 1'b0;
   logic        out_valid, mem_read, mem_write, wb_en, branch, status_update_en, illegal;
   logic [3:0]  exec_command;
   logic [3:0]  xfer_reg_idx;
   logic        xfer_first, xfer_last, busy;

   always #5 clk = ~clk;

   control_unit_seq #(
      .MODE_LEN(2), .OPCODE_LEN(4), .EXEC_CMD_LEN(4), .REG_LIST_W(16), .MUL_CYCLES(MulCycles)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
      .opcode(opcode), .s(s), .reg_list(reg_list), .stall_in(stall_in), .flush(flush),
      .out_valid(out_valid), .exec_command(exec_command), .mem_read(mem_read),
      .mem_write(mem_write), .wb_en(wb_en), .branch(branch),
      .status_update_en(status_update_en), .illegal(illegal), .xfer_reg_idx(xfer_reg_idx),
      .xfer_first(xfer_first), .xfer_last(xfer_last), .busy(busy)
   );

   logic [16:0] dut_word;
   assign dut_word = {out_valid, exec_command, mem_read, mem_write, wb_en, branch,
                      status_update_en, illegal, xfer_reg_idx, xfer_first, xfer_last};

   int n_checks = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: 0 idle, 1 block transfer in progress, 2 MUL occupancy.
   int          m_state = 0;
   int          m_beats[$];
   bit          m_dir = 1'b0;
   int          m_mul_left = 0;
   logic [16:0] m_word = '0;

   function automatic logic [16:0] word(bit v, logic [3:0] ex, bit rd, bit wr, bit wb, bit br,
                                        bit su, bit il, logic [3:0] ix, bit f, bit l);
      return {v, ex, rd, wr, wb, br, su, il, ix, f, l};
   endfunction

   function automatic logic [16:0] arith_word(logic [3:0] op, bit sv);
      logic [3:0] exec_tab [12];
      exec_tab = '{ExecMov, ExecMvn, ExecAdd, ExecAdc, ExecSub, ExecSbc, ExecAnd, ExecOrr,
                   ExecEor, ExecCmp, ExecTst, ExecMul};
      if (op > 4'd11) return word(1, ExecNop, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      return word(1, exec_tab[op], 0, 0, (op != OpCmp && op != OpTst), 0, sv, 0, 0, 0, 0);
   endfunction

   task automatic model_edge();
      int ix;
      if (flush) begin
         m_word = '0;
         m_state = 0;
         m_beats.delete();
         m_mul_left = 0;
      end else if (!stall_in) begin
         m_word = '0;
         if (m_state == 1) begin
            ix = m_beats.pop_front();
            m_word = word(1, ExecMem, m_dir, !m_dir, m_dir, 0, 0, 0, 4'(ix), 0,
                          m_beats.size() == 0);
            if (m_beats.size() == 0) m_state = 0;
         end else if (m_state == 2) begin
            m_mul_left--;
            if (m_mul_left == 0) m_state = 0;
         end else if (in_valid) begin
            case (mode)
               2'd0: begin
                  m_word = arith_word(opcode, s);
                  if (opcode == OpMul && MulCycles > 1) begin
                     m_state = 2;
                     m_mul_left = MulCycles - 1;
                  end
               end
               2'd1: m_word = word(1, ExecMem, s, !s, s, 0, 0, 0, 0, 0, 0);
               2'd2: m_word = word(1, ExecNop, 0, 0, 0, 1, 0, 0, 0, 0, 0);
               default: begin
                  m_dir = s;
                  m_beats.delete();
                  for (int b = 0; b < 16; b++) if (reg_list[b]) m_beats.push_back(b);
                  if (m_beats.size() == 0) begin
                     m_word = word(1, ExecNop, 0, 0, 0, 0, 0, 1, 0, 0, 0);
                  end else begin
                     ix = m_beats.pop_front();
                     m_word = word(1, ExecMem, s, !s, s, 0, 0, 0, 4'(ix), 1,
                                   m_beats.size() == 0);
                     if (m_beats.size() != 0) m_state = 1;
                  end
               end
            endcase
         end
      end
   endtask

   task automatic drive(bit v, logic [1:0] md, logic [3:0] op, bit sv, logic [15:0] rl,
                        bit st, bit fl);
      in_valid = v; mode = md; opcode = op; s = sv; reg_list = rl; stall_in = st; flush = fl;
   endtask

   task automatic step(input string tag);
      #1;
      check_eq({tag, ".in_ready"}, 32'(in_ready), 32'((m_state == 0) && !stall_in));
      @(posedge clk);
      model_edge();
      #1;
      check_eq({tag, ".ctrl"}, 32'(dut_word), 32'(m_word));
      check_eq({tag, ".busy"}, 32'(busy), 32'(m_state != 0));
   endtask

   task automatic idle(input string tag, input int n);
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset.ctrl", 32'(dut_word), 32'h0);
      check_eq("reset.busy", 32'(busy), 32'h0);
      rst_n = 1'b1;

      // ADD with status update, then a bubble.
      drive(1, 2'd0, OpAdd, 1, 0, 0, 0); step("add");
      check_eq("add.exec", 32'(exec_command), 32'(ExecAdd));
      idle("add_bubble", 1);

      // Block load 8421: beats on 0, 5, 10, 15.
      drive(1, 2'd3, 0, 1, 16'h8421, 0, 0); step("ldm");
      drive(1, 2'd1, 0, 1, 0, 0, 0);
      step("ldm"); step("ldm"); step("ldm");
      check_eq("ldm.last_idx", 32'(xfer_reg_idx), 32'd15);
      idle("ldm_tail", 1);

      // Block store 0006 with a 2-cycle stall holding the idx2 beat.
      drive(1, 2'd3, 0, 0, 16'h0006, 0, 0); step("stm");
      drive(0, 0, 0, 0, 0, 0, 0); step("stm");
      drive(0, 0, 0, 0, 0, 1, 0); step("stm_stall"); step("stm_stall");
      check_eq("stm.hold_idx", 32'(xfer_reg_idx), 32'd2);
      idle("stm_tail", 2);

      // MUL occupancy while a new word keeps knocking.
      drive(1, 2'd0, OpMul, 0, 0, 0, 0); step("mul");
      drive(1, 2'd0, OpMov, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step("mul_wait");
      idle("mul_tail", 1);

      // Flush in the middle of a block transfer, then a MOV.
      drive(1, 2'd3, 0, 1, 16'h00FF, 0, 0); step("flush_blk");
      drive(0, 0, 0, 0, 0, 0, 0); step("flush_blk");
      drive(1, 2'd0, OpMov, 0, 0, 0, 1); step("flush");
      drive(1, 2'd0, OpMov, 0, 0, 0, 0); step("mov_after_flush");
      idle("flush_tail", 1);

      // Asynchronous reset mid-block, then an empty block list.
      drive(1, 2'd3, 0, 1, 16'h8421, 0, 0); step("rst_blk");
      drive(0, 0, 0, 0, 0, 0, 0);
      #3 rst_n = 1'b0;
      #1;
      check_eq("async_rst.ctrl", 32'(dut_word), 32'h0);
      check_eq("async_rst.busy", 32'(busy), 32'h0);
      m_state = 0; m_word = '0; m_beats.delete(); m_mul_left = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1, 2'd3, 0, 1, 16'h0000, 0, 0); step("empty_list");
      check_eq("empty_list.illegal", 32'(illegal), 32'd1);
      check_eq("empty_list.mem_read", 32'(mem_read), 32'd0);
      idle("empty_tail", 1);

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         logic [15:0] rl;
         case ($urandom_range(0, 3))
            0: rl = 16'h0;
            1: rl = 16'(32'd1 << $urandom_range(0, 15));
            default: rl = 16'($urandom);
         endcase
         drive($urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), rl, $urandom_range(0, 99) < 15,
               $urandom_range(0, 99) < 5);
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
